uart_cmd_ctrl: RTL and testbench

Frame decoder and write sequencer between the UART receiver and the on-chip write ports. It consumes the receiver's byte stream (one-cycle `data_ready` strobe per byte) and parses framed commands. It issues sequential writes either to the 64 KiB C64 memory port (valid/ready handshake) or to the 64-entry VIC-II register file (single-cycle strobe). It also reports checksum, timeout, overrun and bad-command errors.

---
 rtl/uart_cmd_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Frame decoder and write sequencer between the UART receiver and the memory / VIC-II write ports.
// Frame: SYNC CMD ADDR_LO ADDR_HI LEN payload[LEN] CSUM, where CSUM is the XOR of CMD..last payload.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CLKS = 64125000 / 32 / 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [5:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        busy,
  output logic        frame_ok,
  output logic [3:0]  err
);

  typedef enum logic [2:0] {
    StHunt, StCmd, StAlo, StAhi, StLen, StData, StCsum
  } state_e;

  localparam logic [31:0] ToLast = 32'(TIMEOUT_CLKS - 1);

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        is_reg_q, is_reg_d;
  logic [15:0] addr_q, addr_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [5:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        reg_we_q, reg_we_d;
  logic        frame_ok_q, frame_ok_d;
  logic [3:0]  err_q, err_d;

  logic        write_stall;
  logic        consume;
  logic        overrun;
  logic        timeout;
  logic [31:0] to_cnt_inc;

  // An unaccepted memory write blocks the FSM; the next byte waits in the holding register.
  assign write_stall = mem_we_q & ~mem_ready;
  assign consume     = hold_full_q & ~write_stall;
  assign overrun     = rx_ready & hold_full_q & ~consume;
  assign busy        = (state_q != StHunt);
  assign to_cnt_inc  = (to_cnt_q == ToLast) ? to_cnt_q : to_cnt_q + 32'd1;
  assign timeout     = busy & ~rx_ready & (to_cnt_inc == ToLast) & ~write_stall;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    is_reg_d    = is_reg_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    csum_d      = csum_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = write_stall;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    frame_ok_d  = 1'b0;
    err_d       = 4'b0000;

    if (!busy || rx_ready) begin
      to_cnt_d = 32'd0;
    end else begin
      to_cnt_d = to_cnt_inc;
    end

    if (consume) begin
      hold_full_d = 1'b0;
    end
    if (rx_ready && !overrun) begin
      hold_d      = rx_data;
      hold_full_d = 1'b1;
    end

    if (overrun) begin
      err_d       = 4'b0100;
      hold_full_d = 1'b0;
      state_d     = StHunt;
    end else if (timeout) begin
      err_d       = 4'b0010;
      hold_full_d = 1'b0;
      state_d     = StHunt;
    end else if (consume) begin
      unique case (state_q)
        StHunt: begin
          if (hold_q == SYNC_BYTE) begin
            state_d = StCmd;
          end
        end
        StCmd: begin
          if (hold_q == 8'h01 || hold_q == 8'h02) begin
            is_reg_d = (hold_q == 8'h02);
            csum_d   = hold_q;
            state_d  = StAlo;
          end else begin
            err_d   = 4'b1000;
            state_d = StHunt;
          end
        end
        StAlo: begin
          addr_d[7:0] = hold_q;
          csum_d      = csum_q ^ hold_q;
          state_d     = StAhi;
        end
        StAhi: begin
          addr_d[15:8] = hold_q;
          csum_d       = csum_q ^ hold_q;
          state_d      = StLen;
        end
        StLen: begin
          rem_d   = (hold_q == 8'h00) ? 9'd256 : {1'b0, hold_q};
          csum_d  = csum_q ^ hold_q;
          state_d = StData;
        end
        StData: begin
          if (is_reg_q) begin
            reg_addr_d  = addr_q[5:0];
            reg_wdata_d = hold_q;
            reg_we_d    = 1'b1;
          end else begin
            mem_addr_d  = addr_q;
            mem_wdata_d = hold_q;
            mem_we_d    = 1'b1;
          end
          addr_d = addr_q + 16'd1;
          rem_d  = rem_q - 9'd1;
          csum_d = csum_q ^ hold_q;
          if (rem_q == 9'd1) begin
            state_d = StCsum;
          end
        end
        StCsum: begin
          if (hold_q == csum_q) begin
            frame_ok_d = 1'b1;
          end else begin
            err_d = 4'b0001;
          end
          state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      is_reg_q    <= 1'b0;
      addr_q      <= 16'h0000;
      rem_q       <= 9'd0;
      csum_q      <= 8'h00;
      to_cnt_q    <= 32'd0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      reg_addr_q  <= 6'd0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      is_reg_q    <= is_reg_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      csum_q      <= csum_d;
      to_cnt_q    <= to_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      frame_ok_q  <= frame_ok_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign frame_ok  = frame_ok_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed + randomized bench for uart_cmd_ctrl; expected writes come from a frame-level model.
module tb_uart_cmd_ctrl;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        busy;
  logic        frame_ok;
  logic [3:0]  err;

  uart_cmd_ctrl #(
    .TIMEOUT_CLKS(TO),
    .SYNC_BYTE   (8'h55)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_ready(mem_ready),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .busy     (busy),
    .frame_ok (frame_ok),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory ready: either a directed level, or 5 low cycles per write when bp_en is set.
  logic ready_lvl = 1'b1;
  logic bp_en = 1'b0;
  int   bp_wait = 0;
  always begin
    @(posedge clk);
    #2;
    if (bp_en) begin
      if (mem_we && bp_wait < 5) begin
        mem_ready = 1'b0;
        bp_wait   = bp_wait + 1;
      end else if (mem_we) begin
        mem_ready = 1'b1;
        bp_wait   = 0;
      end else begin
        mem_ready = 1'b0;
        bp_wait   = 0;
      end
    end else begin
      mem_ready = ready_lvl;
    end
  end

  // Monitor: logs every accepted write and every pulse, sampled mid-cycle.
  logic [23:0] mem_log[$];
  logic [23:0] reg_log[$];
  int          ok_cnt = 0;
  int          err_cnt[4] = '{0, 0, 0, 0};
  int          multi_err = 0;
  int          unstable = 0;
  int unsigned last_rx_cyc = 0;
  int unsigned we_lat = 0;
  int unsigned ok_lat = 0;
  int unsigned err1_lat = 0;
  logic        prev_we = 1'b0;
  logic        prev_ready = 1'b0;
  logic [23:0] prev_wr = '0;

  always @(negedge clk) begin
    if (rx_ready) last_rx_cyc <= cyc;
    if (mem_we && mem_ready) mem_log.push_back({mem_addr, mem_wdata});
    if (reg_we) reg_log.push_back({10'd0, reg_addr, reg_wdata});
    if (mem_we && !prev_we) we_lat <= cyc - last_rx_cyc;
    if (frame_ok) begin
      ok_cnt <= ok_cnt + 1;
      ok_lat <= cyc - last_rx_cyc;
    end
    if (err[1]) err1_lat <= cyc - last_rx_cyc;
    for (int i = 0; i < 4; i++) begin
      if (err[i]) err_cnt[i] <= err_cnt[i] + 1;
    end
    if ($countones(err) > 1) multi_err <= multi_err + 1;
    if (!rst && prev_we && !prev_ready && !(mem_we && {mem_addr, mem_wdata} == prev_wr)) begin
      unstable <= unstable + 1;
    end
    prev_we    <= mem_we;
    prev_ready <= mem_ready;
    prev_wr    <= {mem_addr, mem_wdata};
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: bytes to send and the writes they must produce.
  logic [7:0]  tx_q[$];
  logic [7:0]  pay_q[$];
  logic [23:0] exp_q[$];

  task automatic build_frame(input logic [7:0] cmd, input logic [15:0] addr, input bit bad_csum);
    logic [7:0]  cs;
    int unsigned a;
    tx_q.delete();
    exp_q.delete();
    tx_q.push_back(8'h55);
    tx_q.push_back(cmd);
    tx_q.push_back(addr[7:0]);
    tx_q.push_back(addr[15:8]);
    tx_q.push_back(8'(pay_q.size()));
    cs = cmd ^ addr[7:0] ^ addr[15:8] ^ 8'(pay_q.size());
    for (int i = 0; i < pay_q.size(); i++) begin
      tx_q.push_back(pay_q[i]);
      cs = cs ^ pay_q[i];
      a  = (int'(addr) + i) % 65536;
      if (cmd == 8'h02) exp_q.push_back({10'd0, 6'(a % 64), pay_q[i]});
      else exp_q.push_back({16'(a), pay_q[i]});
    end
    if (bad_csum) cs = cs ^ 8'(1 + $urandom_range(0, 254));
    tx_q.push_back(cs);
  endtask

  task automatic rand_pay(input int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
  endtask

  // Called at posedge+1; gap < 0 selects a random 0..2 idle cycles per byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_tx(input int gap);
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_writes(input string tag, input bit is_reg, input int base);
    int n;
    int bad;
    n = is_reg ? reg_log.size() - base : mem_log.size() - base;
    chk({tag, "_count"}, 64'(n), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= n) bad++;
      else if ((is_reg ? reg_log[base + i] : mem_log[base + i]) !== exp_q[i]) bad++;
    end
    chk({tag, "_data"}, 64'(bad), 64'd0);
  endtask

  int mb, rb, okb;
  int eb[4];
  task automatic snap();
    mb  = mem_log.size();
    rb  = reg_log.size();
    okb = ok_cnt;
    for (int i = 0; i < 4; i++) eb[i] = err_cnt[i];
  endtask

  function automatic int err_sum_delta();
    return (err_cnt[0] - eb[0]) + (err_cnt[1] - eb[1]) + (err_cnt[2] - eb[2]) +
           (err_cnt[3] - eb[3]);
  endfunction

  initial begin
    logic [7:0]  cmd;
    logic [15:0] addr;
    int          len;
    bit          bad;
    bit          seen;

    rst      = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({mem_addr, mem_wdata, mem_we, reg_addr, reg_wdata, reg_we, busy,
                              frame_ok, err}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Memory frame, ready tied high, one idle cycle between bytes.
    snap();
    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    build_frame(8'h01, 16'h0400, 1'b0);
    send_tx(1);
    idle(4);
    check_writes("memA", 1'b0, mb);
    chk("memA_frame_ok", 64'(ok_cnt - okb), 64'd1);
    chk("memA_err", 64'(err_sum_delta()), 64'd0);
    chk("memA_we_latency", 64'(we_lat), 64'd2);
    chk("memA_ok_latency", 64'(ok_lat), 64'd2);

    // Register frame wrapping 3F -> 00.
    snap();
    pay_q = '{8'h11, 8'h22, 8'h33};
    build_frame(8'h02, 16'h003E, 1'b0);
    send_tx(0);
    idle(4);
    check_writes("regWrap", 1'b1, rb);
    chk("regWrap_frame_ok", 64'(ok_cnt - okb), 64'd1);
    chk("regWrap_err", 64'(err_sum_delta()), 64'd0);

    // Backpressure with a corrupted checksum.
    snap();
    bp_en = 1'b1;
    rand_pay(3);
    build_frame(8'h01, 16'h1234, 1'b1);
    send_tx(10);
    idle(10);
    bp_en = 1'b0;
    idle(2);
    check_writes("bp", 1'b0, mb);
    chk("bp_stable", 64'(unstable), 64'd0);
    chk("bp_err0", 64'(err_cnt[0] - eb[0]), 64'd1);
    chk("bp_no_frame_ok", 64'(ok_cnt - okb), 64'd0);

    // Timeout after a truncated header, then a normal frame.
    snap();
    send_byte(8'h55, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    idle(120);
    chk("to_err1", 64'(err_cnt[1] - eb[1]), 64'd1);
    chk("to_latency", 64'(err1_lat), 64'(TO));
    chk("to_busy_low", 64'(busy), 64'd0);
    snap();
    rand_pay(5);
    build_frame(8'h01, 16'h8000, 1'b0);
    send_tx(-1);
    idle(4);
    check_writes("afterTo", 1'b0, mb);
    chk("afterTo_frame_ok", 64'(ok_cnt - okb), 64'd1);

    // Overrun: memory stalled while payload keeps arriving.
    snap();
    ready_lvl = 1'b0;
    idle(1);
    pay_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    build_frame(8'h01, 16'h2000, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(tx_q[i], 1);
    idle(3);
    chk("ovr_err2", 64'(err_cnt[2] - eb[2]), 64'd1);
    chk("ovr_busy_low", 64'(busy), 64'd0);
    ready_lvl = 1'b1;
    idle(4);
    chk("ovr_write_count", 64'(mem_log.size() - mb), 64'd1);
    chk("ovr_write", 64'(mem_log[mb]), 64'({16'h2000, 8'h5A}));

    // Bad command.
    snap();
    send_byte(8'h55, 1);
    send_byte(8'h07, 1);
    idle(3);
    chk("badcmd_err3", 64'(err_cnt[3] - eb[3]), 64'd1);
    chk("badcmd_no_writes", 64'((mem_log.size() - mb) + (reg_log.size() - rb)), 64'd0);
    chk("badcmd_busy_low", 64'(busy), 64'd0);

    // Memory address wrap FFFF -> 0000.
    snap();
    rand_pay(2);
    build_frame(8'h01, 16'hFFFF, 1'b0);
    send_tx(-1);
    idle(4);
    check_writes("memWrap", 1'b0, mb);
    chk("memWrap_frame_ok", 64'(ok_cnt - okb), 64'd1);

    // Asynchronous reset during an outstanding write.
    snap();
    ready_lvl = 1'b0;
    idle(1);
    pay_q = '{8'h99, 8'h98};
    build_frame(8'h01, 16'h3000, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(tx_q[i], 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_we;
    end
    rst = 1'b1;
    #1;
    chk("rst_drops_we", 64'(mem_we), 64'd0);
    chk("rst_outputs", 64'({mem_addr, mem_wdata, mem_we, reg_addr, reg_wdata, reg_we, busy,
                            frame_ok, err}), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ready_lvl = 1'b1;
    idle(3);
    chk("rst_write_abandoned", 64'(mem_log.size() - mb), 64'd0);

    // Randomized frames; the first one uses LEN=0 (256 bytes).
    for (int f = 0; f < 6; f++) begin
      snap();
      cmd  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      addr = 16'($urandom);
      len  = (f == 0) ? 256 : int'($urandom_range(1, 12));
      bad  = ($urandom_range(0, 3) == 0);
      rand_pay(len);
      build_frame(cmd, addr, bad);
      send_tx(-1);
      idle(4);
      check_writes($sformatf("rand%0d", f), cmd == 8'h02, (cmd == 8'h02) ? rb : mb);
      chk($sformatf("rand%0d_frame_ok", f), 64'(ok_cnt - okb), 64'(!bad));
      chk($sformatf("rand%0d_err0", f), 64'(err_cnt[0] - eb[0]), 64'(bad));
    end

    chk("single_err_bit", 64'(multi_err), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
